// File: rtl/dram_req_arbiter_if.sv
// ----------------------------------------------------------------------------
// dram_req_arbiter_if
// Bundles the requester-side and controller-side signals of the DRAM request
// arbiter.
//   master : requesters plus the controller model. Drives the requests and the
//            controller status flags, and receives accepts, responses and
//            controller commands.
//   slave  : the arbiter. It has the opposite direction on every signal.
// Signal groups:
//   req_*  : per-requester request lanes (packed, requester i at slice i).
//   rsp_*  : per-requester response pulse plus shared read data and timeout.
//   ctl_*  : command outputs to the controller and status flags back from it.
// ----------------------------------------------------------------------------
interface dram_req_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int U_ADDR_WIDTH = 13,
    parameter int U_DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_cmd;
    logic [NUM_REQ*U_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*U_DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]              req_accept;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic [U_DATA_WIDTH-1:0]         rsp_rdata;
    logic                            rsp_timeout;
    logic                            ctl_en;
    logic                            ctl_cmd;
    logic [U_ADDR_WIDTH-1:0]         ctl_addr;
    logic [U_DATA_WIDTH-1:0]         ctl_wdata;
    logic                            ctl_cmd_ack;
    logic                            ctl_busy;
    logic                            ctl_data_valid;
    logic [U_DATA_WIDTH-1:0]         ctl_rdata;

    modport master (
        output req_valid, req_cmd, req_addr, req_wdata,
        output ctl_cmd_ack, ctl_busy, ctl_data_valid, ctl_rdata,
        input  req_accept, rsp_valid, rsp_rdata, rsp_timeout,
        input  ctl_en, ctl_cmd, ctl_addr, ctl_wdata
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, req_wdata,
        input  ctl_cmd_ack, ctl_busy, ctl_data_valid, ctl_rdata,
        output req_accept, rsp_valid, rsp_rdata, rsp_timeout,
        output ctl_en, ctl_cmd, ctl_addr, ctl_wdata
    );
endinterface

// File: rtl/dram_req_arbiter.sv
// ----------------------------------------------------------------------------
// dram_req_arbiter
// Round-robin arbiter and single-outstanding transaction sequencer that shares
// one DRAM controller user port among NUM_REQ requesters. A watchdog counter
// aborts any transaction that the controller never completes.
// Ports:
//   u_clk : sole clock (rising edge)
//   u_rst : asynchronous active-high reset
//   bus   : slave side of dram_req_arbiter_if. It carries the req_*/rsp_*
//           requester signals and the ctl_* controller signals. Every output
//           is registered.
// ----------------------------------------------------------------------------
module dram_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int U_ADDR_WIDTH   = 13,
    parameter int U_DATA_WIDTH   = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  u_clk,
    input  logic                  u_rst,
    dram_req_arbiter_if.slave     bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_WAIT_DATA = 3'd5;
    localparam logic [2:0] S_RESP      = 3'd6;

    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [2:0]              state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      req_accept_q, req_accept_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [U_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    ctl_en_q, ctl_en_d;
    logic                    ctl_cmd_q, ctl_cmd_d;
    logic [U_ADDR_WIDTH-1:0] ctl_addr_q, ctl_addr_d;
    logic [U_DATA_WIDTH-1:0] ctl_wdata_q, ctl_wdata_d;

    int                      rr_idx_s;
    logic [PTR_W-1:0]        cand_s;
    logic [PTR_W-1:0]        grant_idx_s;
    logic                    found_s;

    // Round-robin search: scan rr_ptr+1 .. rr_ptr+NUM_REQ and keep the first hit.
    always_comb begin
        rr_idx_s    = 0;
        cand_s      = {PTR_W{1'b0}};
        grant_idx_s = {PTR_W{1'b0}};
        found_s     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx_s    = (int'(rr_ptr_q) + k) % NUM_REQ;
            cand_s      = PTR_W'(rr_idx_s);
            grant_idx_s = (bus.req_valid[cand_s] && !found_s) ? cand_s : grant_idx_s;
            found_s     = found_s | bus.req_valid[cand_s];
        end
    end

    // Transaction FSM with watchdog; computes next state and every output register.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        ctl_cmd_d     = ctl_cmd_q;
        ctl_addr_d    = ctl_addr_q;
        ctl_wdata_d   = ctl_wdata_q;
        req_accept_d  = {NUM_REQ{1'b0}};
        rsp_rdata_d   = {U_DATA_WIDTH{1'b0}};
        rsp_timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A busy controller (e.g. self-refresh) blocks new grants.
                if ((|bus.req_valid) && !bus.ctl_busy) begin
                    state_d      = S_ISSUE;
                    rr_ptr_d     = grant_idx_s;
                    cnt_d        = {CNT_W{1'b0}};
                    ctl_cmd_d    = bus.req_cmd[grant_idx_s];
                    ctl_addr_d   = bus.req_addr[grant_idx_s*U_ADDR_WIDTH +: U_ADDR_WIDTH];
                    ctl_wdata_d  = bus.req_wdata[grant_idx_s*U_DATA_WIDTH +: U_DATA_WIDTH];
                    req_accept_d = ONE_HOT_0 << grant_idx_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE, S_WAIT_ACK, S_WAIT_BUSY, S_WAIT_DONE, S_WAIT_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                // The timeout wins over any completion flag seen in the same cycle.
                if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d       = S_RESP;
                    rsp_timeout_d = 1'b1;
                end else begin
                    case (state_q)
                        S_ISSUE: state_d = S_WAIT_ACK;
                        S_WAIT_ACK: begin
                            // A data_valid coinciding with the ack is not consumed here.
                            if (bus.ctl_cmd_ack) begin
                                state_d = ctl_cmd_q ? S_WAIT_BUSY : S_WAIT_DATA;
                            end else begin
                                state_d = S_WAIT_ACK;
                            end
                        end
                        S_WAIT_BUSY: begin
                            if (bus.ctl_busy) begin
                                state_d = S_WAIT_DONE;
                            end else begin
                                state_d = S_WAIT_BUSY;
                            end
                        end
                        S_WAIT_DONE: begin
                            if (!bus.ctl_busy) begin
                                state_d = S_RESP;
                            end else begin
                                state_d = S_WAIT_DONE;
                            end
                        end
                        S_WAIT_DATA: begin
                            if (bus.ctl_data_valid) begin
                                state_d     = S_RESP;
                                rsp_rdata_d = bus.ctl_rdata;
                            end else begin
                                state_d = S_WAIT_DATA;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // S_RESP is entered only from an active state, where rr_ptr holds the grant.
        rsp_valid_d = (state_d == S_RESP) ? (ONE_HOT_0 << rr_ptr_q) : {NUM_REQ{1'b0}};
        ctl_en_d    = (state_d != S_IDLE) && (state_d != S_RESP);
    end

    // State and output registers; async reset points rr_ptr at the last requester.
    always_ff @(posedge u_clk or posedge u_rst) begin
        if (u_rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= PTR_W'(NUM_REQ - 1);
            cnt_q         <= {CNT_W{1'b0}};
            req_accept_q  <= {NUM_REQ{1'b0}};
            rsp_valid_q   <= {NUM_REQ{1'b0}};
            rsp_rdata_q   <= {U_DATA_WIDTH{1'b0}};
            rsp_timeout_q <= 1'b0;
            ctl_en_q      <= 1'b0;
            ctl_cmd_q     <= 1'b0;
            ctl_addr_q    <= {U_ADDR_WIDTH{1'b0}};
            ctl_wdata_q   <= {U_DATA_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            req_accept_q  <= req_accept_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            ctl_en_q      <= ctl_en_d;
            ctl_cmd_q     <= ctl_cmd_d;
            ctl_addr_q    <= ctl_addr_d;
            ctl_wdata_q   <= ctl_wdata_d;
        end
    end

    assign bus.req_accept  = req_accept_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.ctl_en      = ctl_en_q;
    assign bus.ctl_cmd     = ctl_cmd_q;
    assign bus.ctl_addr    = ctl_addr_q;
    assign bus.ctl_wdata   = ctl_wdata_q;
endmodule

// File: tb/tb_dram_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dram_req_arbiter
// Directed testbench for dram_req_arbiter, with TIMEOUT_CYCLES = 8. Each
// scenario task drives its own stimulus and checks against hand-computed values.
// Inputs change 1 ns after a rising edge, and outputs are sampled at the same
// point. "Cycle T" is the cycle in which the bench presents a request.
// ----------------------------------------------------------------------------
module tb_dram_req_arbiter;
    localparam int NR = 4;
    localparam int AW = 13;
    localparam int DW = 8;
    localparam int TO = 8;

    logic u_clk;
    logic u_rst;
    int   checks = 0;
    int   errors = 0;

    dram_req_arbiter_if #(.NUM_REQ(NR), .U_ADDR_WIDTH(AW), .U_DATA_WIDTH(DW)) bus ();

    dram_req_arbiter #(
        .NUM_REQ(NR), .U_ADDR_WIDTH(AW), .U_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .u_clk (u_clk),
        .u_rst (u_rst),
        .bus   (bus)
    );

    initial u_clk = 1'b0;
    always #5 u_clk = ~u_clk;

    task automatic step();
        @(posedge u_clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid      = 4'b0000;
        bus.req_cmd        = 4'b0000;
        bus.req_addr       = {(NR*AW){1'b0}};
        bus.req_wdata      = {(NR*DW){1'b0}};
        bus.ctl_cmd_ack    = 1'b0;
        bus.ctl_busy       = 1'b0;
        bus.ctl_data_valid = 1'b0;
        bus.ctl_rdata      = 8'h00;
    endtask

    task automatic do_reset();
        u_rst = 1'b1;
        clear_inputs();
        step();
        step();
        u_rst = 1'b0;
    endtask

    task automatic test_reset();
        u_rst = 1'b1;
        clear_inputs();
        bus.req_valid = 4'b1111;
        step();
        step();
        checks++; if (bus.req_accept !== 4'b0000) begin errors++; $display("FAIL reset_req_accept: got %b expected 0000", bus.req_accept); end
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid); end
        checks++; if (bus.ctl_en !== 1'b0 || bus.ctl_cmd !== 1'b0) begin errors++; $display("FAIL reset_ctl_en_cmd: got %b%b expected 00", bus.ctl_en, bus.ctl_cmd); end
        checks++; if (bus.ctl_addr !== 13'h0000 || bus.ctl_wdata !== 8'h00) begin errors++; $display("FAIL reset_ctl_addr_wdata: got %h/%h expected 0000/00", bus.ctl_addr, bus.ctl_wdata); end
        checks++; if (bus.rsp_rdata !== 8'h00 || bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL reset_rsp_data: got %h/%b expected 00/0", bus.rsp_rdata, bus.rsp_timeout); end
        bus.req_valid = 4'b0000;
        u_rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_cmd   = 4'b0000;
        bus.req_addr[2*AW +: AW] = 13'h00A5;
        step(); // T+1
        checks++; if (bus.req_accept !== 4'b0100) begin errors++; $display("FAIL read_accept: got %b expected 0100", bus.req_accept); end
        checks++; if (bus.ctl_en !== 1'b1 || bus.ctl_cmd !== 1'b0 || bus.ctl_addr !== 13'h00A5) begin errors++; $display("FAIL read_issue: got en=%b cmd=%b addr=%h expected en=1 cmd=0 addr=00a5", bus.ctl_en, bus.ctl_cmd, bus.ctl_addr); end
        bus.req_valid = 4'b0000;
        step(); // T+2
        bus.ctl_cmd_ack = 1'b1;
        step(); // T+3
        bus.ctl_cmd_ack = 1'b0;
        checks++; if (bus.ctl_en !== 1'b1 || bus.rsp_valid !== 4'b0000 || bus.req_accept !== 4'b0000) begin errors++; $display("FAIL read_wait: got en=%b rsp=%b acc=%b expected en=1 rsp=0000 acc=0000", bus.ctl_en, bus.rsp_valid, bus.req_accept); end
        step(); // T+4
        step(); // T+5
        step(); // T+6
        bus.ctl_data_valid = 1'b1;
        bus.ctl_rdata      = 8'h3C;
        step(); // T+7
        bus.ctl_data_valid = 1'b0;
        bus.ctl_rdata      = 8'h00;
        checks++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_rdata !== 8'h3C || bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL read_rsp: got v=%b d=%h to=%b expected v=0100 d=3c to=0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout); end
        checks++; if (bus.ctl_en !== 1'b0) begin errors++; $display("FAIL read_en_in_resp: got %b expected 0", bus.ctl_en); end
        step(); // T+8
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL read_rsp_pulse: got %b expected 0000", bus.rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_acc;
        int         who;
        int         wait_cnt;
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_cmd   = 4'b1111;
        bus.req_addr  = {13'h0103, 13'h0102, 13'h0101, 13'h0100};
        bus.req_wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int n = 0; n < 5; n++) begin
            who     = n % 4;
            exp_acc = 4'b0001 << who;
            wait_cnt = 0;
            while (bus.req_accept === 4'b0000 && wait_cnt < 20) begin
                step();
                wait_cnt++;
            end
            checks++; if (bus.req_accept !== exp_acc) begin errors++; $display("FAIL rr_accept[%0d]: got %b expected %b", n, bus.req_accept, exp_acc); end
            checks++; if (bus.ctl_cmd !== 1'b1 || bus.ctl_addr !== (13'h0100 + 13'(who)) || bus.ctl_wdata !== (8'hA0 + 8'(who))) begin errors++; $display("FAIL rr_fields[%0d]: got cmd=%b addr=%h wd=%h expected cmd=1 addr=%h wd=%h", n, bus.ctl_cmd, bus.ctl_addr, bus.ctl_wdata, 13'h0100 + 13'(who), 8'hA0 + 8'(who)); end
            step(); // T+2 WAIT_ACK
            bus.ctl_cmd_ack = 1'b1;
            step(); // T+3 WAIT_BUSY
            bus.ctl_cmd_ack = 1'b0;
            bus.ctl_busy    = 1'b1;
            step(); // T+4 WAIT_DONE
            bus.ctl_busy    = 1'b0;
            step(); // T+5 RESP
            checks++; if (bus.rsp_valid !== exp_acc || bus.rsp_timeout !== 1'b0 || bus.rsp_rdata !== 8'h00) begin errors++; $display("FAIL rr_rsp[%0d]: got v=%b to=%b d=%h expected v=%b to=0 d=00", n, bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, exp_acc); end
        end
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        bus.req_valid = 4'b0011;
        bus.ctl_rdata = 8'hFF;
        step(); // T+1
        checks++; if (bus.req_accept !== 4'b0001) begin errors++; $display("FAIL to_accept0: got %b expected 0001", bus.req_accept); end
        bus.req_valid = 4'b0010;
        bad = 0;
        for (int c = 0; c < 7; c++) begin
            step(); // T+2 .. T+8
            if (bus.rsp_valid !== 4'b0000) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL to_early_rsp: got %0d early responses expected 0", bad); end
        step(); // T+9
        checks++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_timeout !== 1'b1 || bus.rsp_rdata !== 8'h00 || bus.ctl_en !== 1'b0) begin errors++; $display("FAIL to_rsp0: got v=%b to=%b d=%h en=%b expected v=0001 to=1 d=00 en=0", bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, bus.ctl_en); end
        step(); // T+10 grant decision
        step(); // T+11 = A
        checks++; if (bus.req_accept !== 4'b0010) begin errors++; $display("FAIL to_accept1: got %b expected 0010", bus.req_accept); end
        bus.req_valid = 4'b0000;
        for (int c = 0; c < 7; c++) step(); // A+7
        bus.ctl_cmd_ack = 1'b1; // coincides with the timeout, must lose
        step(); // A+8
        bus.ctl_cmd_ack = 1'b0;
        checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_timeout !== 1'b1 || bus.rsp_rdata !== 8'h00) begin errors++; $display("FAIL to_override: got v=%b to=%b d=%h expected v=0010 to=1 d=00", bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata); end
    endtask

    task automatic test_busy_block();
        int bad;
        do_reset();
        bus.ctl_busy  = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_addr[0 +: AW] = 13'h01F0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.req_accept !== 4'b0000 || bus.ctl_en !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL busy_block: got %0d grant cycles expected 0", bad); end
        bus.ctl_busy = 1'b0;
        step(); // C+1
        checks++; if (bus.req_accept !== 4'b0001 || bus.ctl_addr !== 13'h01F0) begin errors++; $display("FAIL busy_release: got acc=%b addr=%h expected acc=0001 addr=01f0", bus.req_accept, bus.ctl_addr); end
        bus.req_valid = 4'b0000;
        step(); // C+2 WAIT_ACK: ack and data together
        bus.ctl_cmd_ack    = 1'b1;
        bus.ctl_data_valid = 1'b1;
        bus.ctl_rdata      = 8'h11;
        step(); // C+3
        bus.ctl_cmd_ack    = 1'b0;
        bus.ctl_data_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL simul_c3: got %b expected 0000", bus.rsp_valid); end
        step(); // C+4
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL simul_c4: got %b expected 0000", bus.rsp_valid); end
        bus.ctl_data_valid = 1'b1;
        bus.ctl_rdata      = 8'h22;
        step(); // C+5
        bus.ctl_data_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata !== 8'h22) begin errors++; $display("FAIL simul_rsp: got v=%b d=%h expected v=0001 d=22", bus.rsp_valid, bus.rsp_rdata); end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_addr[2*AW +: AW] = 13'h0055;
        step(); // T+1
        bus.req_valid = 4'b0000;
        step(); // T+2
        bus.ctl_cmd_ack = 1'b1;
        step(); // T+3 WAIT_DATA
        bus.ctl_cmd_ack = 1'b0;
        checks++; if (bus.ctl_en !== 1'b1) begin errors++; $display("FAIL mid_pre_en: got %b expected 1", bus.ctl_en); end
        u_rst = 1'b1;
        #1;
        checks++; if (bus.ctl_en !== 1'b0 || bus.req_accept !== 4'b0000 || bus.rsp_valid !== 4'b0000 || bus.ctl_addr !== 13'h0000 || bus.ctl_cmd !== 1'b0 || bus.ctl_wdata !== 8'h00 || bus.rsp_rdata !== 8'h00 || bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL mid_async: got en=%b acc=%b rsp=%b addr=%h expected all 0", bus.ctl_en, bus.req_accept, bus.rsp_valid, bus.ctl_addr); end
        step();
        u_rst = 1'b0;
        bus.ctl_data_valid = 1'b1; // late data for the aborted read
        bus.ctl_rdata      = 8'h77;
        bus.req_valid      = 4'b0101;
        step();
        bus.ctl_data_valid = 1'b0;
        checks++; if (bus.req_accept !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b expected 0001", bus.req_accept); end
        bus.req_valid = 4'b0100;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.rsp_valid !== 4'b0000) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_stale_rsp: got %0d responses expected 0", bad); end
    endtask

    task automatic test_stray_and_fast_read();
        int bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            bus.ctl_cmd_ack    = (c == 1);
            bus.ctl_data_valid = (c == 2);
            bus.ctl_rdata      = 8'h5A;
            step();
            if (bus.req_accept !== 4'b0000 || bus.rsp_valid !== 4'b0000 || bus.ctl_en !== 1'b0 || bus.rsp_rdata !== 8'h00) bad++;
        end
        bus.ctl_cmd_ack    = 1'b0;
        bus.ctl_data_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL stray_idle: got %0d active cycles expected 0", bad); end
        bus.req_valid = 4'b1000;
        bus.req_addr[3*AW +: AW] = 13'h00AB;
        step(); // T+1
        checks++; if (bus.req_accept !== 4'b1000 || bus.ctl_addr !== 13'h00AB) begin errors++; $display("FAIL fast_accept: got acc=%b addr=%h expected acc=1000 addr=00ab", bus.req_accept, bus.ctl_addr); end
        bus.req_valid = 4'b0000;
        step(); // T+2
        bus.ctl_cmd_ack = 1'b1;
        step(); // T+3
        bus.ctl_cmd_ack    = 1'b0;
        bus.ctl_data_valid = 1'b1;
        bus.ctl_rdata      = 8'hC3;
        step(); // T+4
        bus.ctl_data_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 4'b1000 || bus.rsp_rdata !== 8'hC3 || bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL fast_rsp: got v=%b d=%h to=%b expected v=1000 d=c3 to=0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout); end
    endtask

    initial begin
        u_rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_busy_block();
        test_reset_mid();
        test_stray_and_fast_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dram_req_arbiter.md
# dram_req_arbiter

Round-robin arbiter and transaction sequencer that shares one `dram_controller` user port among `NUM_REQ` requesters. It accepts one request at a time and drives the controller's command inputs. It tracks completion through the controller's ack, busy and read-valid flags, then returns a per-requester response. A timeout aborts any transaction the controller never completes, for example a command dropped in favour of a refresh.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `U_ADDR_WIDTH`, 13: controller address width, `<bank, row, col>`.
- `U_DATA_WIDTH`, 8: data width.
- `TIMEOUT_CYCLES`, 64: maximum cycles from ISSUE to completion (≥8).
- `u_clk`  in  1  sole clock; all logic on its rising edge.
- `u_rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_cmd`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*U_ADDR_WIDTH  requester i at `[i*U_ADDR_WIDTH +: U_ADDR_WIDTH]`.
- `req_wdata`  in  NUM_REQ*U_DATA_WIDTH  requester i at `[i*U_DATA_WIDTH +: U_DATA_WIDTH]`.
- `req_accept`  out  NUM_REQ  one-hot, one-cycle pulse: request captured.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle pulse: transaction finished.
- `rsp_rdata`  out  U_DATA_WIDTH  read data, qualified by `rsp_valid`.
- `rsp_timeout`  out  1  transaction aborted, qualified by `rsp_valid`.
- `ctl_en`, `ctl_cmd`, `ctl_addr`, `ctl_wdata`  out  1/1/U_ADDR_WIDTH/U_DATA_WIDTH  to controller `u_en`/`u_cmd`/`u_addr`/`u_data_i`.
- `ctl_cmd_ack`, `ctl_busy`, `ctl_data_valid`, `ctl_rdata`  in  1/1/1/U_DATA_WIDTH  from controller.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset state is S_IDLE, `rr_ptr = NUM_REQ-1` so requester 0 wins first, and the timeout counter is 0.
- Requester contract: hold `req_valid`, `req_cmd`, `req_addr` and `req_wdata` stable until `req_accept` is seen. Any change before that is undefined.
- Round-robin grant: search indices `rr_ptr+1 … rr_ptr+NUM_REQ` (mod NUM_REQ); the first index with a set `req_valid` bit wins. On grant, `rr_ptr` takes the winning index.
- States:
  - S_IDLE: if `|req_valid` and `!ctl_busy`, grant, latch the winner's fields into the `ctl_*` registers, pulse `req_accept[g]`, clear the timeout counter → S_ISSUE. Otherwise stay.
  - S_ISSUE (1 cycle): `ctl_en = 1` → S_WAIT_ACK.
  - S_WAIT_ACK: on `ctl_cmd_ack`, write → S_WAIT_BUSY, read → S_WAIT_DATA.
  - S_WAIT_BUSY: on `ctl_busy = 1` → S_WAIT_DONE.
  - S_WAIT_DONE: on `ctl_busy = 0` → S_RESP with `rsp_rdata = 0`.
  - S_WAIT_DATA: on `ctl_data_valid`, capture `ctl_rdata` → S_RESP.
  - S_RESP (1 cycle): `rsp_valid[g] = 1` → S_IDLE.
- `ctl_en` is high from S_ISSUE through the last wait state and low in S_IDLE and S_RESP. `ctl_cmd`, `ctl_addr` and `ctl_wdata` hold the latched values until the next grant.
- Timeout: the counter increments every cycle in S_ISSUE and in the wait states. On reaching `TIMEOUT_CYCLES` → S_RESP with `rsp_timeout = 1` and `rsp_rdata = 0`; this overrides any completion event in the same cycle.
- Controller flags are ignored outside the state that consumes them; a stray `ctl_cmd_ack` in S_IDLE has no effect.
- Simultaneous: if `ctl_data_valid` arrives in the same cycle as `ctl_cmd_ack` in S_WAIT_ACK, only the ack is consumed; completion requires a later valid.
- Reset mid-transaction aborts silently: no `rsp_valid`, `ctl_en` drops immediately (asynchronous reset).
- Only one transaction is outstanding at a time; requests arriving meanwhile wait in S_IDLE arbitration.

## Timing
- Grant decision in S_IDLE cycle T. `req_accept` and `ctl_en` are high in T+1 (S_ISSUE).
- Earliest `rsp_valid` for a read is T+4: ack in T+2, data valid in T+3, response in T+4.
- The earliest cycle after `rsp_valid` in which a new grant can be decided is the next cycle. Back-to-back grants are therefore spaced by transaction length + 2.
- Timeout response fires in cycle T+1+TIMEOUT_CYCLES.
- `ctl_busy = 1` in S_IDLE blocks the grant, for example during a controller-initiated refresh.

## Test plan
- Single read from requester 2, addr 0x0A5: ack at T+2, `ctl_data_valid` with 0x3C at T+6 → `req_accept = 4'b0100` at T+1, `rsp_valid = 4'b0100`, `rsp_rdata = 0x3C`, `rsp_timeout = 0` at T+7.
- All four requesters hold writes continuously → grants in order 0,1,2,3,0 with no requester granted twice before the others; each write completes via busy rising then falling.
- Controller never acks (`TIMEOUT_CYCLES = 8`) → `rsp_valid[g]` with `rsp_timeout = 1` at T+9, then the next requester is granted.
- `ctl_busy` held high for 20 cycles in S_IDLE with `req_valid = 4'b0001` → no `req_accept` until busy falls, then grant.
- Assert `u_rst` while in S_WAIT_DATA → every output reads 0 the same cycle; after release the first grant goes to requester 0 and no stale `rsp_valid` appears.
- Stray `ctl_cmd_ack` and `ctl_data_valid` pulses while in S_IDLE with no requests → no state change, no outputs.
